// File: rtl/seq_mealy_pkg.sv
// Shared helpers for the seq_mealy pattern detector: state sizing and the
// elaboration-time KMP next-state function.
package seq_mealy_pkg;

    function automatic int unsigned state_width(input int unsigned len);
        return (len < 2) ? 1 : $clog2(len);
    endfunction

    // Longest suffix of (first k pattern bits, then b) that is a proper prefix of the pattern.
    function automatic int unsigned kmp_next(
        input logic [15:0]  pattern,
        input int unsigned  len,
        input int unsigned  k,
        input logic         b
    );
        int unsigned best;
        int unsigned idx;
        logic        ok;
        logic        sb;
        logic        pb;
        logic [15:0] tmp;
        best = 0;
        for (int unsigned j = 1; j <= 16; j++) begin
            if (j <= k + 1 && j < len) begin
                ok = 1'b1;
                for (int unsigned i = 0; i < 16; i++) begin
                    if (i < j) begin
                        idx = k + 1 - j + i;
                        if (idx == k) begin
                            sb = b;
                        end else begin
                            tmp = pattern >> (len - 1 - idx);
                            sb  = tmp[0];
                        end
                        tmp = pattern >> (len - 1 - i);
                        pb  = tmp[0];
                        if (sb != pb) ok = 1'b0;
                    end
                end
                if (ok) best = j;
            end
        end
        return best;
    endfunction

endpackage

// File: rtl/seq_mealy_ns.sv
// Combinational next-state and match logic for seq_mealy; transition tables
// are fixed at elaboration from PATTERN.
module seq_mealy_ns
    import seq_mealy_pkg::*;
#(
    parameter int unsigned                 PATTERN_LEN = 4,
    parameter logic [PATTERN_LEN-1:0]      PATTERN     = 4'b1010,
    parameter bit                          OVERLAP     = 1'b1,
    localparam int unsigned                SW          = state_width(PATTERN_LEN)
) (
    input  logic [SW-1:0] state,
    input  logic          x,
    output logic [SW-1:0] state_nxt,
    output logic          match
);

    localparam int unsigned NS = 1 << SW;

    function automatic logic [SW-1:0] next_of(input int unsigned k, input logic b);
        if (!OVERLAP && k == PATTERN_LEN - 1 && b == PATTERN[0]) return '0;
        return SW'(kmp_next(16'(PATTERN), PATTERN_LEN, k, b));
    endfunction

    logic [NS-1:0][SW-1:0] tab0;
    logic [NS-1:0][SW-1:0] tab1;

    // Unreachable codes (non power-of-two lengths) fall back to idle.
    for (genvar k = 0; k < NS; k++) begin : g_tab
        if (k < PATTERN_LEN) begin : g_live
            assign tab0[k] = next_of(k, 1'b0);
            assign tab1[k] = next_of(k, 1'b1);
        end else begin : g_dead
            assign tab0[k] = '0;
            assign tab1[k] = '0;
        end
    end

    always_comb begin
        state_nxt = x ? tab1[state] : tab0[state];
        match     = (state == SW'(PATTERN_LEN - 1)) && (x == PATTERN[0]);
    end

endmodule

// File: rtl/seq_mealy.sv
// Mealy serial pattern detector: async active-low reset state register plus
// combinational match output.
module seq_mealy
    import seq_mealy_pkg::*;
#(
    parameter int unsigned            PATTERN_LEN = 4,
    parameter logic [PATTERN_LEN-1:0] PATTERN     = 4'b1010,
    parameter bit                     OVERLAP     = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic x,
    output logic z
);

    localparam int unsigned SW = state_width(PATTERN_LEN);

    logic [SW-1:0] state;
    logic [SW-1:0] state_nxt;
    logic          match;

    seq_mealy_ns #(
        .PATTERN_LEN (PATTERN_LEN),
        .PATTERN     (PATTERN),
        .OVERLAP     (OVERLAP)
    ) u_ns (
        .state     (state),
        .x         (x),
        .state_nxt (state_nxt),
        .match     (match)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= '0;
        else        state <= state_nxt;
    end

    assign z = match;

endmodule

// File: tb/tb_seq_mealy.sv
// Scoreboard bench for seq_mealy: default, non-overlapping and 3-bit "111" instances.
module tb_seq_mealy;

    logic       clk;
    logic       reset;
    logic       x;
    logic [2:0] zs;

    typedef struct {
        int   dut;
        logic z;
        int   tag;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    int   tag   = 0;

    seq_mealy u_d0 (.clk(clk), .reset(reset), .x(x), .z(zs[0]));

    seq_mealy #(.PATTERN_LEN(4), .PATTERN(4'b1010), .OVERLAP(1'b0))
        u_d1 (.clk(clk), .reset(reset), .x(x), .z(zs[1]));

    seq_mealy #(.PATTERN_LEN(3), .PATTERN(3'b111), .OVERLAP(1'b1))
        u_d2 (.clk(clk), .reset(reset), .x(x), .z(zs[2]));

    initial begin
        clk = 1'b0;
        forever #20 clk = ~clk;
    end

    // x changes on the falling edge; z is checked 10 ns later, well before the rising edge.
    always @(negedge clk) begin
        exp_t e;
        #10;
        if (q.size() > 0) begin
            e = q.pop_front();
            total++;
            if (zs[e.dut] !== e.z) begin
                bad++;
                $display("FAIL z_d%0d_vec%0d got=%b want=%b", e.dut, e.tag, zs[e.dut], e.z);
            end
        end
    end

    task automatic bitv(input int dut, input logic rst, input logic b, input logic e);
        exp_t n;
        @(negedge clk);
        reset = rst;
        x     = b;
        n.dut = dut;
        n.z   = e;
        n.tag = tag;
        tag++;
        q.push_back(n);
    endtask

    task automatic stream(input int dut, input int len, input logic [15:0] bits, input logic [15:0] exp);
        logic [15:0] bb;
        logic [15:0] ee;
        bb = bits;
        ee = exp;
        for (int i = len - 1; i >= 0; i--) bitv(dut, 1'b1, bb[i], ee[i]);
    endtask

    task automatic do_reset(input int dut);
        bitv(dut, 1'b0, 1'b1, 1'b0);
    endtask

    initial begin
        exp_t n;
        reset = 1'b0;
        x     = 1'b0;

        // Reset held with x=1, then 1010
        bitv(0, 1'b0, 1'b1, 1'b0);
        bitv(0, 1'b0, 1'b1, 1'b0);
        stream(0, 4, 16'b1010, 16'b0001);

        // Overlap, default parameters
        do_reset(0);
        stream(0, 11, 16'b01011010101, 16'b00000001010);

        // Non-overlapping instance, same stream
        do_reset(1);
        stream(1, 11, 16'b01011010101, 16'b00000001000);

        // Mismatch fallback
        do_reset(0);
        stream(0, 5, 16'b11010, 16'b00001);
        do_reset(0);
        stream(0, 7, 16'b1001010, 16'b0000001);

        // Mid-pattern async reset pulsed between edges
        do_reset(0);
        stream(0, 3, 16'b101, 16'b000);
        @(negedge clk);
        x     = 1'b0;
        n.dut = 0;
        n.z   = 1'b0;
        n.tag = tag;
        tag++;
        q.push_back(n);
        reset = 1'b0;
        #5;
        reset = 1'b1;
        stream(0, 4, 16'b1010, 16'b0001);

        // Alternate parameters: 111 with overlap
        do_reset(2);
        stream(2, 5, 16'b11111, 16'b00111);

        for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
        #15;
        if (q.size() > 0) begin
            bad++;
            $display("FAIL drain pending=%0d want=0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout got=running want=finished");
        $fatal(1, "timeout");
    end

endmodule
